dmem_arbiter: RTL and testbench

Two-port arbiter that shares one single-port, synchronous-read data memory between the CPU load/store port (port 0) and a secondary master (port 1, e.g. UART program loader / debug DMA). It issues at most one access per cycle, uses a burst-limited round-robin policy, and routes read data back to the port that issued the read. It sits between the CPU memory stage and the DMEM/BIOS block RAM.

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the two-port data memory arbiter.
// The arbiter connects through the slave modport; bench/requesters use master.
interface dmem_arbiter_if #(
    parameter int AWIDTH = 14
);
    logic              req0;
    logic              req1;
    logic [3:0]        we0;
    logic [3:0]        we1;
    logic [AWIDTH-1:0] addr0;
    logic [AWIDTH-1:0] addr1;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [31:0]       rdata0;
    logic [31:0]       rdata1;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1,
        input  wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1,
        output wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Burst-limited round-robin arbiter sharing one synchronous-read data memory
// between the CPU load/store port (0) and a secondary master (1).
module dmem_arbiter #(
    parameter int AWIDTH    = 14,
    parameter int MAX_BURST = 4
) (
    input logic            clk,
    input logic            rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    localparam logic [3:0] BURST = 4'(MAX_BURST);

    owner_t     owner_q;
    owner_t     owner_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] cnt_inc;
    logic       last_q;
    logic       last_d;
    logic [1:0] rd_pend_q;
    logic       pick1;
    logic       g0;
    logic       g1;

    assign cnt_inc = (cnt_q == 4'hf) ? 4'hf : cnt_q + 4'd1;

    // pick1 only matters when both ports request
    always_comb begin
        pick1 = 1'b0;
        unique case (owner_q)
            OWN0:    pick1 = (cnt_q >= BURST);
            OWN1:    pick1 = (cnt_q < BURST);
            default: pick1 = ~last_q;
        endcase
        g0 = rst_n & bus.req0 & (~bus.req1 | ~pick1);
        g1 = rst_n & bus.req1 & (~bus.req0 | pick1);
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (1'b1)
            g0: begin
                last_d = 1'b0;
                if (owner_q == OWN0) begin
                    cnt_d = cnt_inc;
                end else begin
                    owner_d = OWN0;
                    cnt_d   = 4'd1;
                end
            end
            g1: begin
                last_d = 1'b1;
                if (owner_q == OWN1) begin
                    cnt_d = cnt_inc;
                end else begin
                    owner_d = OWN1;
                    cnt_d   = 4'd1;
                end
            end
            default: begin
                owner_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            rd_pend_q <= 2'b00;
        end else begin
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rd_pend_q <= {g1 & ~|bus.we1, g0 & ~|bus.we0};
        end
    end

    assign bus.gnt0    = g0;
    assign bus.gnt1    = g1;
    assign bus.rvalid0 = rd_pend_q[0];
    assign bus.rvalid1 = rd_pend_q[1];
    assign bus.rdata0  = bus.mem_dout;
    assign bus.rdata1  = bus.mem_dout;
    assign bus.mem_en  = g0 | g1;

    always_comb begin
        bus.mem_we   = 4'h0;
        bus.mem_addr = '0;
        bus.mem_din  = 32'h0;
        unique case (1'b1)
            g0: begin
                bus.mem_we   = bus.we0;
                bus.mem_addr = bus.addr0;
                bus.mem_din  = bus.wdata0;
            end
            g1: begin
                bus.mem_we   = bus.we1;
                bus.mem_addr = bus.addr1;
                bus.mem_din  = bus.wdata1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (burst 4 and burst 1),
// each with a small behavioural block RAM.
module tb_dmem_arbiter;
    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    exp_t qa[$];
    exp_t qb[$];
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    dmem_arbiter_if #(.AWIDTH(14)) ia ();
    dmem_arbiter_if #(.AWIDTH(14)) ib ();

    dmem_arbiter #(.AWIDTH(14), .MAX_BURST(4)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    dmem_arbiter #(.AWIDTH(14), .MAX_BURST(1)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAMs: preset words reloaded on reset, byte-write, sync read
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_a[16] <= 32'hDEADBEEF;
            mem_a[17] <= 32'hCAFEF00D;
            mem_b[16] <= 32'h11111111;
            mem_b[17] <= 32'h22222222;
        end else begin
            if (ia.mem_en) begin
                if (ia.mem_we == 4'h0) ia.mem_dout <= mem_a[ia.mem_addr[7:0]];
                for (int b = 0; b < 4; b++)
                    if (ia.mem_we[b]) mem_a[ia.mem_addr[7:0]][8*b +: 8] <= ia.mem_din[8*b +: 8];
            end
            if (ib.mem_en) begin
                if (ib.mem_we == 4'h0) ib.mem_dout <= mem_b[ib.mem_addr[7:0]];
                for (int b = 0; b < 4; b++)
                    if (ib.mem_we[b]) mem_b[ib.mem_addr[7:0]][8*b +: 8] <= ib.mem_din[8*b +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic rv_check(input string nm, input logic v0, input logic v1,
                            input logic [31:0] d0, input logic [31:0] d1, input exp_t e);
        int          p;
        logic [31:0] d;
        p = v1 ? 1 : 0;
        d = v1 ? d1 : d0;
        vectors++;
        if ((v0 && v1) || e.port != p || d !== e.data) begin
            miscompares++;
            $display("FAIL %s: got rv0=%b rv1=%b data %h, required port %0d data %h",
                     nm, v0, v1, d, e.port, e.data);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && (ia.rvalid0 || ia.rvalid1)) begin
            if (qa.size() != 0) e = qa.pop_front();
            else e = '{port: -1, data: 32'h0};
            rv_check("rvalid_a", ia.rvalid0, ia.rvalid1, ia.rdata0, ia.rdata1, e);
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && (ib.rvalid0 || ib.rvalid1)) begin
            if (qb.size() != 0) e = qb.pop_front();
            else e = '{port: -1, data: 32'h0};
            rv_check("rvalid_b", ib.rvalid0, ib.rvalid1, ib.rdata0, ib.rdata1, e);
        end
    end

    task automatic drive(input bit inst,
                         input logic r0, input logic [3:0] w0, input logic [13:0] a0, input logic [31:0] d0,
                         input logic r1, input logic [3:0] w1, input logic [13:0] a1, input logic [31:0] d1);
        if (!inst) begin
            ia.req0 = r0; ia.we0 = w0; ia.addr0 = a0; ia.wdata0 = d0;
            ia.req1 = r1; ia.we1 = w1; ia.addr1 = a1; ia.wdata1 = d1;
        end else begin
            ib.req0 = r0; ib.we0 = w0; ib.addr0 = a0; ib.wdata0 = d0;
            ib.req1 = r1; ib.we1 = w1; ib.addr1 = a1; ib.wdata1 = d1;
        end
    endtask

    // One clock cycle: drive, check grant and memory bus, queue read returns
    task automatic cyc(input bit inst,
                       input logic r0, input logic [3:0] w0, input logic [13:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] w1, input logic [13:0] a1, input logic [31:0] d1,
                       input logic eg0, input logic eg1, input logic [31:0] ed0, input logic [31:0] ed1);
        logic [52:0] got;
        logic [52:0] exp;
        @(posedge clk);
        #1;
        drive(inst, r0, w0, a0, d0, r1, w1, a1, d1);
        @(negedge clk);
        if (!inst)
            got = {ia.gnt0, ia.gnt1, ia.mem_en, ia.mem_we, ia.mem_addr, ia.mem_din};
        else
            got = {ib.gnt0, ib.gnt1, ib.mem_en, ib.mem_we, ib.mem_addr, ib.mem_din};
        exp = {eg0, eg1, eg0 | eg1,
               eg0 ? w0 : (eg1 ? w1 : 4'h0),
               eg0 ? a0 : (eg1 ? a1 : 14'h0),
               eg0 ? d0 : (eg1 ? d1 : 32'h0)};
        chk(inst ? "grant_b" : "grant_a", {11'h0, got}, {11'h0, exp});
        if (eg0 && w0 == 4'h0) begin
            if (!inst) qa.push_back('{port: 0, data: ed0});
            else qb.push_back('{port: 0, data: ed0});
        end
        if (eg1 && w1 == 4'h0) begin
            if (!inst) qa.push_back('{port: 1, data: ed1});
            else qb.push_back('{port: 1, data: ed1});
        end
    endtask

    task automatic rd2(input bit inst, input logic [13:0] a0, input logic [13:0] a1,
                       input logic eg0, input logic eg1, input logic [31:0] ed0, input logic [31:0] ed1);
        cyc(inst, 1'b1, 4'h0, a0, 32'h0, 1'b1, 4'h0, a1, 32'h0, eg0, eg1, ed0, ed1);
    endtask

    task automatic idle(input bit inst);
        cyc(inst, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [11:0] pat;
        logic [5:0]  alt;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        ia.mem_dout = 32'h0;
        ib.mem_dout = 32'h0;
        drive(1'b0, 1'b1, 4'h0, 14'h10, 32'h0, 1'b1, 4'h0, 14'h11, 32'h0);
        drive(1'b1, 1'b1, 4'h0, 14'h10, 32'h0, 1'b1, 4'h0, 14'h11, 32'h0);
        #12;
        chk("reset_a", {ia.gnt0, ia.gnt1, ia.mem_en, ia.mem_we, ia.rvalid0, ia.rvalid1}, 64'h0);
        chk("reset_b", {ib.gnt0, ib.gnt1, ib.mem_en, ib.mem_we, ib.rvalid0, ib.rvalid1}, 64'h0);
        drive(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Continuous contention from reset, burst of 4
        pat = 12'b0000_1111_0000;
        for (int i = 0; i < 12; i++)
            rd2(1'b0, 14'h10, 14'h11, ~pat[11-i], pat[11-i], 32'hDEADBEEF, 32'hCAFEF00D);
        idle(1'b0);
        // Last grant was port 0, so contention from idle now favours port 1
        rd2(1'b0, 14'h10, 14'h11, 1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D);
        idle(1'b0);

        // Single port read, port 1 idle
        cyc(1'b0, 1'b1, 4'h0, 14'h10, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0,
            1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
        idle(1'b0);

        // Writes then cross-port reads of the same word
        cyc(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 4'hF, 14'h20, 32'h12345678,
            1'b0, 1'b1, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 4'h0, 14'h20, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0,
            1'b1, 1'b0, 32'h12345678, 32'h0);
        cyc(1'b0, 1'b1, 4'h3, 14'h20, 32'hAABBCCDD, 1'b0, 4'h0, 14'h0, 32'h0,
            1'b1, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 4'h0, 14'h20, 32'h0,
            1'b0, 1'b1, 32'h0, 32'h1234CCDD);
        idle(1'b0);

        // 17 solo grants saturate cnt at 15, so port 1 wins at once
        for (int i = 0; i < 17; i++)
            cyc(1'b0, 1'b1, 4'h0, 14'h10, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0,
                1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
        rd2(1'b0, 14'h10, 14'h11, 1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D);
        idle(1'b0);

        // Burst of 1: strict alternation from reset state
        alt = 6'b010101;
        for (int i = 0; i < 6; i++)
            rd2(1'b1, 14'h10, 14'h11, ~alt[5-i], alt[5-i], 32'h11111111, 32'h22222222);
        idle(1'b1);
        idle(1'b1);

        // Reset in the middle of a port 1 read burst
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 4'h0, 14'h11, 32'h0);
        @(posedge clk);
        #1 chk("pre_reset", {ia.gnt1, ia.rvalid1, ia.rdata1}, {30'h0, 1'b1, 1'b1, 32'hCAFEF00D});
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {ia.gnt0, ia.gnt1, ia.mem_en, ia.mem_we, ia.rvalid0, ia.rvalid1}, 64'h0);
        drive(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("release", {ia.rvalid0, ia.rvalid1, ia.mem_en}, 64'h0);
        rd2(1'b0, 14'h10, 14'h11, 1'b1, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
        idle(1'b0);
        idle(1'b0);

        chk("queue_a_empty", 64'(qa.size()), 64'h0);
        chk("queue_b_empty", 64'(qb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
